// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the multiply/divide unit.
//   WIDTH      operand/result width (only 32 is supported)
//   op_e       operation encoding carried on the op port
//   state_e    iteration controller states
//   DIV0_QUOT  quotient reported for a zero divisor
//   magnitude  absolute value of an operand, unsigned when is_signed=0
package muldiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Counter value of the final radix-2 iteration.
    localparam logic [4:0] LAST_ITER = 5'd31;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of the most negative value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath.
//   is_div   0: shift-add multiply step, 1: restoring divide step
//   part_hi  multiply: running high product / divide: partial remainder
//   part_lo  multiply: multiplier bits still to consume / divide: dividend
//            bits shifting out while quotient bits shift in
//   operand  multiplicand magnitude (multiply) or divisor magnitude (divide)
//   next_hi, next_lo  the pair after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] part_hi,
    input  logic [WIDTH-1:0] part_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);
    import muldiv_pkg::*;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // Single iteration: add-and-shift-right or compare-subtract-shift-left.
    always_comb begin
        sum_s     = {1'b0, part_hi}
                  + (part_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s = {part_hi, part_lo[WIDTH-1]};
        // The remainder is always below the divisor, so a successful
        // subtraction fits in WIDTH bits and the borrow bit can be dropped.
        diff_s    = shifted_s[WIDTH-1:0] - operand;
        next_hi   = part_hi;
        next_lo   = part_lo;
        if (is_div) begin
            if (shifted_s >= {1'b0, operand}) begin
                next_hi = diff_s;
                next_lo = {part_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted_s[WIDTH-1:0];
                next_lo = {part_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi = sum_s[WIDTH:1];
            next_lo = {sum_s[0], part_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   start, op, a, b  operation request, sampled only while idle
//   wr_hi, wr_lo     direct HI/LO write from wr_data, honoured only while idle
//   busy             operation in progress
//   done             one-cycle pulse when hi/lo hold a fresh result
//   hi, lo           result registers
// Fixed latency: done is high in the 34th cycle after the start edge.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};

    state_e           state_r;
    state_e           state_nx;
    logic [4:0]       cnt_r;
    op_e              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] mag_r;
    logic [WIDTH-1:0] work_hi_r;
    logic [WIDTH-1:0] work_lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             busy_r;

    logic             start_div_s;
    logic             start_signed_s;
    logic             is_div_s;
    logic             is_signed_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Decode of the requested op (at start) and of the latched op.
    always_comb begin
        start_div_s    = op[1];
        start_signed_s = ~op[0];
        is_div_s       = (op_r == OP_DIV) || (op_r == OP_DIVU);
        is_signed_s    = (op_r == OP_MULT) || (op_r == OP_DIV);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_s),
        .part_hi (work_hi_r),
        .part_lo (work_lo_r),
        .operand (mag_r),
        .next_hi (step_hi_s),
        .next_lo (step_lo_s)
    );

    // Controller state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_ITER) begin
                    state_nx = ST_FIX;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sign correction of the unsigned iteration result, plus the
    // divide-by-zero override (hi keeps the raw dividend).
    always_comb begin
        prod_s     = {work_hi_r, work_lo_r};
        prod_neg_s = (~prod_s) + ONE_2W;
        fix_hi_s   = work_hi_r;
        fix_lo_s   = work_lo_r;
        if (!is_div_s) begin
            if (is_signed_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) begin
                {fix_hi_s, fix_lo_s} = prod_neg_s;
            end else begin
                {fix_hi_s, fix_lo_s} = prod_s;
            end
        end else if (b_r == ZERO_W) begin
            fix_hi_s = a_r;
            fix_lo_s = DIV0_QUOT;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            if (is_signed_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) begin
                fix_lo_s = (~work_lo_r) + ONE_W;
            end else begin
                fix_lo_s = work_lo_r;
            end
            if (is_signed_s && a_r[WIDTH-1]) begin
                fix_hi_s = (~work_hi_r) + ONE_W;
            end else begin
                fix_hi_s = work_hi_r;
            end
        end
    end

    // Operand latch, iteration counter and working pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= 5'd0;
            op_r      <= OP_MULT;
            a_r       <= ZERO_W;
            b_r       <= ZERO_W;
            mag_r     <= ZERO_W;
            work_hi_r <= ZERO_W;
            work_lo_r <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r      <= op_e'(op);
                        a_r       <= a;
                        b_r       <= b;
                        cnt_r     <= 5'd0;
                        work_hi_r <= ZERO_W;
                        // Multiply consumes the multiplier from lo; divide
                        // shifts the dividend out of lo into the remainder.
                        if (start_div_s) begin
                            work_lo_r <= magnitude(a, start_signed_s);
                            mag_r     <= magnitude(b, start_signed_s);
                        end else begin
                            work_lo_r <= magnitude(b, start_signed_s);
                            mag_r     <= magnitude(a, start_signed_s);
                        end
                    end
                end
                ST_RUN: begin
                    work_hi_r <= step_hi_s;
                    work_lo_r <= step_lo_s;
                    cnt_r     <= cnt_r + 5'd1;
                end
                ST_FIX: begin
                    cnt_r <= 5'd0;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Architectural HI/LO, done pulse and busy flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_r   <= ZERO_W;
            lo_r   <= ZERO_W;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIX);
            busy_r <= (state_nx != ST_IDLE);
            if (state_r == ST_FIX) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else if (state_r == ST_IDLE) begin
                if (wr_hi) begin
                    hi_r <= wr_data;
                end
                if (wr_lo) begin
                    lo_r <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and done cycle are queued
// when an operation is issued; a monitor pops and compares on every done.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic from the MIPS HI/LO rules, returns {hi,lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint p;
        int sx;
        int sy;
        logic [63:0] r;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                p = longint'(sx) * longint'(sy);
                r = p;
            end
            2'b01: r = {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0)                               r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else                                          r = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else            r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_hi_lo", {hi, lo}, {e.hi, e.lo});
                check("done_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a negedge with busy=0; leaves us one negedge later.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic wr);
        exp_t e;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc + 34;
        sb_q.push_back(e);
        op      = o;
        a       = x;
        b       = y;
        start   = 1'b1;
        wr_hi   = wr;
        wr_lo   = wr;
        wr_data = $urandom;
        @(negedge clock);
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    // Waits (bounded) for busy to drop, optionally driving junk meanwhile.
    task automatic wait_idle(input bit noise, input bit chk_busy);
        int n;
        n = 0;
        while (busy && n < 100) begin
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                op      = 2'($urandom_range(0, 3));
                a       = $urandom;
                b       = $urandom;
                wr_hi   = 1'($urandom_range(0, 1));
                wr_lo   = 1'($urandom_range(0, 1));
                wr_data = $urandom;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy still 1 after %0d cycles expected 0", n);
        end else if (chk_busy) begin
            check("busy_cycles", 64'(n), 64'd33);
        end
    endtask

    logic [31:0] corners [5];

    initial begin
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        check("reset_hi_lo", {hi, lo}, 64'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed results with spec-given values.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b11, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b0);
        wait_idle(1'b0, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        wait_idle(1'b0, 1'b1);

        // Busy window: start and wr_hi during RUN are ignored.
        issue(2'b00, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FE0C, 1'b0);
        repeat (3) @(negedge clock);
        start   = 1'b1;
        op      = 2'b01;
        a       = 32'h55;
        b       = 32'h66;
        wr_hi   = 1'b1;
        wr_data = 32'h1234;
        @(negedge clock);
        start = 1'b0;
        wr_hi = 1'b0;
        wait_idle(1'b0, 1'b0);
        wr_lo   = 1'b1;
        wr_data = 32'hABCD;
        @(negedge clock);
        wr_lo = 1'b0;
        check("wr_lo_after_done", {hi, lo}, {32'hFFFF_FFFF, 32'h0000_ABCD});

        // Randomised operations, back-to-back, with junk while busy.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [63:0] ex;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            ex = ref_model(ro, ra, rb);
            issue(ro, ra, rb, ex[63:32], ex[31:0], 1'($urandom_range(0, 1)));
            wait_idle(1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset abort in the middle of RUN.
        issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_busy_done", {62'h0, busy, done}, 64'h0);
        check("abort_hi_lo", {hi, lo}, 64'h0);
        sb_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_idle", {62'h0, busy, done}, 64'h0);
        issue(2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);
        wait_idle(1'b0, 1'b1);

        repeat (3) @(negedge clock);
        check("all_results_seen", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request an operation; sampled only when busy=0.
REQ-006 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 a  input  32  operand 1 (rs value from gpr); multiplicand or dividend.
REQ-008 b  input  32  operand 2 (rt value from gpr); multiplier or divisor.
REQ-009 wr_hi, wr_lo  input  1 each  direct write of hi/lo (MTHI/MTLO).
REQ-010 wr_data  input  32  data for wr_hi/wr_lo.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse: hi/lo hold a new result.
REQ-013 hi, lo  output  32 each  result registers, readable at any time (MFHI/MFLO).

Function
REQ-014 SHALL use FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-015 IDLE: start=1 at edge E0 latches op, a, b; state goes to RUN with iteration counter = 0.
REQ-016 RUN: one radix-2 iteration per cycle (shift-add multiply / restoring divide) on operand magnitudes; after the 32nd iteration (edge E32), state goes to FIX.
REQ-017 FIX: at edge E33, signs are applied, hi/lo are written, done is set to 1 for exactly one cycle, and state returns to IDLE.
REQ-018 Latency is fixed: done is high in the cycle after E33 for every op and operand value, including divide-by-zero.
REQ-019 Multiply: {hi,lo} = full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-020 Divide: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
REQ-021 Divide-by-zero (b=0 latched at start, DIV or DIVU): hi = a, lo = 0xFFFFFFFF; no exception signal.
REQ-022 Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-023 Operands are latched at E0; changes on a, b, op while busy have no effect.
REQ-024 start while busy=1 is ignored and not queued.
REQ-025 start in the cycle where done=1 is accepted, because state is already IDLE.
REQ-026 wr_hi/wr_lo update hi/lo at the next edge only when busy=0; they are ignored while busy.
REQ-027 wr_hi/wr_lo asserted in the same IDLE cycle as start: the write takes effect and the operation starts; the later result overwrites it.
REQ-028 hi/lo hold their value between writes; they do not change during RUN.

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, and the latched operands to 0.
REQ-030 Reset during RUN or FIX aborts the operation with no done pulse; the first start after reset release behaves per REQ-015.

Structure
REQ-031 A shared package muldiv_pkg SHALL hold: the op encodings, the FSM state enum, WIDTH, and the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-032 One sub-module, muldiv_step, SHALL be used: combinational, one iteration (add-shift or compare-subtract-shift), selected by a mul/div flag.
REQ-033 Sign handling (magnitudes at start, negation in FIX) SHALL live in muldiv_unit.

Verification
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done exactly 33 cycles after the start edge; busy high throughout.
REQ-035 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB (-21); then DIVU a=7 b=2 -> lo=3 hi=1.
REQ-036 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-037 DIVU a=5 b=0 -> hi=5 lo=0xFFFFFFFF, same 33-cycle latency; DIV a=0xFFFFFFF9 b=0 -> hi=0xFFFFFFF9 lo=0xFFFFFFFF.
REQ-038 Busy-window checks: start a MULT; during RUN pulse start with new operands and wr_hi with wr_data=0x1234 -> both ignored, only the MULT result appears; after done, wr_lo with 0xABCD -> lo=0xABCD next cycle.
REQ-039 Reset abort: reset_n=0 at RUN iteration 10 -> busy=0, hi=lo=0 asynchronously, no done pulse; after release, start MULTU 3*4 -> lo=12 hi=0 after 33 cycles.
